// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard of in-flight destinations between ID and write-back, driving operand
// forwarding selects, load-use stalls and branch flushes. Define HAZARD_FORWARD_EN to enable bypassing.
module hazard_ctrl #(
   parameter int RBITS    = 5,
   parameter int DEPTH    = 2,
   parameter int LOAD_LAT = 1,
   parameter int SELW     = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [RBITS-1:0] id_rs1,
   input  logic [RBITS-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [RBITS-1:0] id_rd,
   input  logic             id_is_load,
   input  logic             ex_branch_taken,
   output logic             stall,
   output logic             flush,
   output logic [SELW-1:0]  fwd_sel_j,
   output logic [SELW-1:0]  fwd_sel_k,
   output logic [31:0]      stall_cycles
);

   localparam logic [SELW-1:0] AVAIL_ALU  = SELW'(1);
   localparam logic [SELW-1:0] AVAIL_LOAD = SELW'(1 + LOAD_LAT);
   localparam logic [31:0]     CNT_MAX    = 32'hFFFF_FFFF;

   // Stage s of the scoreboard describes the instruction currently in post-ID stage s.
   logic             sb_valid [1:DEPTH];
   logic [RBITS-1:0] sb_rd    [1:DEPTH];
   logic [SELW-1:0]  sb_avail [1:DEPTH];

   logic             issue;
   logic [1:0]       hazard;
   logic [RBITS-1:0] src_reg  [2];
   logic [1:0]       src_use;
   logic [SELW-1:0]  src_sel  [2];
   logic [31:0]      stall_cnt;

   assign src_reg[0] = id_rs1;
   assign src_reg[1] = id_rs2;
   assign src_use[0] = id_use_rs1;
   assign src_use[1] = id_use_rs2;

   assign flush = reset | ex_branch_taken;
   assign stall = id_valid & (|hazard) & ~flush;
   assign issue = id_valid & ~stall & ~flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 1; s <= DEPTH; s++) begin
            sb_valid[s] <= 1'b0;
            sb_rd[s]    <= '0;
            sb_avail[s] <= '0;
         end
      end else begin
         sb_valid[1] <= issue & (id_rd != '0);
         sb_rd[1]    <= issue ? id_rd : '0;
         sb_avail[1] <= (issue & id_is_load) ? AVAIL_LOAD : AVAIL_ALU;
         for (int s = 2; s <= DEPTH; s++) begin
            sb_valid[s] <= sb_valid[s-1];
            sb_rd[s]    <= sb_rd[s-1];
            sb_avail[s] <= sb_avail[s-1];
         end
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         logic            hit;
         logic [SELW-1:0] hit_stage;
         logic [SELW-1:0] hit_avail;

         // Scan oldest to youngest so the youngest matching producer is the one kept.
         always_comb begin
            hit       = 1'b0;
            hit_stage = '0;
            hit_avail = '0;
            for (int s = DEPTH; s >= 1; s--) begin
               if (src_use[gi] && sb_valid[s] && (sb_rd[s] == src_reg[gi]) &&
                   (src_reg[gi] != '0)) begin
                  hit       = 1'b1;
                  hit_stage = SELW'(s);
                  hit_avail = sb_avail[s];
               end
            end
         end

`ifdef HAZARD_FORWARD_EN
         logic early;
         assign early       = hit & (hit_stage < hit_avail);
         assign hazard[gi]  = early;
         assign src_sel[gi] = (hit && !early && !reset) ? hit_stage : '0;
`else
         // Without bypassing the operand waits until the producer has left the last stage.
         logic unused_fwd;
         assign unused_fwd  = ^{hit_stage, hit_avail};
         assign hazard[gi]  = hit;
         assign src_sel[gi] = '0;
`endif
      end
   endgenerate

   assign fwd_sel_j = src_sel[0];
   assign fwd_sel_k = src_sel[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed pipeline scenarios plus random traffic, checked every cycle against an
// issue-history model of the hazard rules (honours HAZARD_FORWARD_EN the same way as the design).
module tb_hazard_ctrl;

   localparam int RBITS    = 5;
   localparam int DEPTH    = 2;
   localparam int LOAD_LAT = 1;
   localparam int SELW     = $clog2(DEPTH + 1);
`ifdef HAZARD_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             id_valid;
   logic [RBITS-1:0] id_rs1;
   logic [RBITS-1:0] id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic [RBITS-1:0] id_rd;
   logic             id_is_load;
   logic             ex_branch_taken;
   logic             stall;
   logic             flush;
   logic [SELW-1:0]  fwd_sel_j;
   logic [SELW-1:0]  fwd_sel_k;
   logic [31:0]      stall_cycles;

   int vectors     = 0;
   int miscompares = 0;

   hazard_ctrl #(
      .RBITS(RBITS), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SELW(SELW)
   ) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_is_load(id_is_load),
      .ex_branch_taken(ex_branch_taken), .stall(stall), .flush(flush),
      .fwd_sel_j(fwd_sel_j), .fwd_sel_k(fwd_sel_k), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   // hist[a] is whatever entered the pipe a edges ago (a bubble has v = 0).
   typedef struct packed {
      logic             v;
      logic [RBITS-1:0] rd;
      logic             ld;
   } rec_t;
   rec_t            hist [1:DEPTH];
   longint unsigned m_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic void op_eval(input logic u, input logic [RBITS-1:0] r,
                                   output logic haz, output int sel);
      haz = 1'b0;
      sel = 0;
      if (u && r != 0) begin
         for (int a = 1; a <= DEPTH; a++) begin
            if (hist[a].v && hist[a].rd == r) begin
               if (FWD && a >= (hist[a].ld ? 1 + LOAD_LAT : 1)) sel = a;
               else haz = 1'b1;
               break;
            end
         end
      end
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int a = 1; a <= DEPTH; a++) hist[a] = '0;
         m_cnt = 0;
      end else begin
         logic h1, h2, st, fl;
         int   s1, s2;
         op_eval(id_use_rs1, id_rs1, h1, s1);
         op_eval(id_use_rs2, id_rs2, h2, s2);
         fl = ex_branch_taken;
         st = id_valid && (h1 || h2) && !fl;
         for (int a = DEPTH; a >= 2; a--) hist[a] = hist[a-1];
         if (id_valid && !st && !fl) hist[1] = '{v: (id_rd != 0), rd: id_rd, ld: id_is_load};
         else hist[1] = '0;
         if (st && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      end
   end

   always @(negedge clk) begin
      logic h1, h2, e_flush, e_stall;
      int   s1, s2;
      op_eval(id_use_rs1, id_rs1, h1, s1);
      op_eval(id_use_rs2, id_rs2, h2, s2);
      e_flush = reset | ex_branch_taken;
      e_stall = !e_flush && id_valid && (h1 || h2);
      check("cyc_flush", 32'(flush), 32'(e_flush));
      check("cyc_stall", 32'(stall), 32'(e_stall));
      check("cyc_sel_j", 32'(fwd_sel_j), 32'(s1));
      check("cyc_sel_k", 32'(fwd_sel_k), 32'(s2));
      check("cyc_count", stall_cycles, m_cnt[31:0]);
   end

   task automatic put(input int v, input int rs1, input int rs2, input int u1, input int u2,
                      input int rd, input int ld, input int br);
      @(posedge clk);
      #1;
      id_valid        = (v != 0);
      id_rs1          = RBITS'(rs1);
      id_rs2          = RBITS'(rs2);
      id_use_rs1      = (u1 != 0);
      id_use_rs2      = (u2 != 0);
      id_rd           = RBITS'(rd);
      id_is_load      = (ld != 0);
      ex_branch_taken = (br != 0);
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) put(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      for (int a = 1; a <= DEPTH; a++) hist[a] = '0;
      m_cnt = 0;
      reset = 1'b1;
      id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      id_rd = '0; id_is_load = 1'b0; ex_branch_taken = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_flush", 32'(flush), 32'd1);
      check("rst_sel_j", 32'(fwd_sel_j), 32'd0);
      check("rst_count", stall_cycles, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      idle(2);

      // ALU producer followed by two consumers
      put(1, 0, 0, 0, 0, 5, 0, 0); mid();
      check("A_addi_stall", 32'(stall), 32'd0);
      put(1, 5, 1, 1, 1, 6, 0, 0); mid();
      check("A_use1_stall", 32'(stall), FWD ? 32'd0 : 32'd1);
      check("A_use1_sel_j", 32'(fwd_sel_j), FWD ? 32'd1 : 32'd0);
      check("A_use1_sel_k", 32'(fwd_sel_k), 32'd0);
      put(1, 5, 1, 1, 1, 6, 0, 0); mid();
      check("A_use2_stall", 32'(stall), FWD ? 32'd0 : 32'd1);
      check("A_use2_sel_j", 32'(fwd_sel_j), FWD ? 32'd2 : 32'd0);
      put(1, 5, 1, 1, 1, 6, 0, 0); mid();
      check("A_use3_stall", 32'(stall), 32'd0);
      check("A_count", stall_cycles, FWD ? 32'd0 : 32'd2);
      idle(3);

      // load-use
      put(1, 0, 0, 0, 0, 5, 1, 0); mid();
      put(1, 5, 5, 1, 1, 6, 0, 0); mid();
      check("B_use1_stall", 32'(stall), 32'd1);
      check("B_use1_sel_j", 32'(fwd_sel_j), 32'd0);
      put(1, 5, 5, 1, 1, 6, 0, 0); mid();
      check("B_use2_stall", 32'(stall), FWD ? 32'd0 : 32'd1);
      check("B_use2_sel_j", 32'(fwd_sel_j), FWD ? 32'd2 : 32'd0);
      check("B_use2_sel_k", 32'(fwd_sel_k), FWD ? 32'd2 : 32'd0);
      check("B_use2_count", stall_cycles, FWD ? 32'd1 : 32'd3);
      put(1, 5, 5, 1, 1, 6, 0, 0); mid();
      check("B_use3_stall", 32'(stall), 32'd0);
      check("B_use3_count", stall_cycles, FWD ? 32'd1 : 32'd4);
      idle(3);

      // writes to x0 never create hazards
      put(1, 0, 0, 0, 0, 0, 1, 0);
      put(1, 0, 0, 0, 0, 0, 0, 0);
      put(1, 0, 0, 1, 1, 7, 0, 0); mid();
      check("C_x0_stall", 32'(stall), 32'd0);
      check("C_x0_sel_j", 32'(fwd_sel_j), 32'd0);
      check("C_x0_sel_k", 32'(fwd_sel_k), 32'd0);
      idle(3);

      // load-use hazard in the same cycle as a taken branch
      put(1, 0, 0, 0, 0, 5, 1, 0); mid();
      put(1, 5, 1, 1, 1, 6, 0, 1); mid();
      check("D_br_flush", 32'(flush), 32'd1);
      check("D_br_stall", 32'(stall), 32'd0);
      put(1, 6, 0, 1, 0, 0, 0, 0); mid();
      check("D_after_flush", 32'(flush), 32'd0);
      check("D_bubble_stall", 32'(stall), 32'd0);
      check("D_bubble_sel_j", 32'(fwd_sel_j), 32'd0);
      check("D_count", stall_cycles, FWD ? 32'd1 : 32'd4);
      idle(3);

      // reset asserted in the middle of a stall
      put(1, 0, 0, 0, 0, 5, 1, 0); mid();
      put(1, 5, 5, 1, 1, 7, 0, 0); mid();
      check("E_pre_stall", 32'(stall), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("E_rst_stall", 32'(stall), 32'd0);
      check("E_rst_flush", 32'(flush), 32'd1);
      check("E_rst_count", stall_cycles, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      idle(2);

      // counter saturation from a preloaded value
      @(negedge clk);
      #2;
      force dut.stall_cnt = 32'hFFFF_FFFE;
      m_cnt = 64'hFFFF_FFFE;
      #1 release dut.stall_cnt;
      mid();
      check("F_preload", stall_cycles, 32'hFFFF_FFFE);
      put(1, 0, 0, 0, 0, 5, 1, 0);
      put(1, 5, 5, 1, 1, 6, 0, 0);
      put(1, 0, 0, 0, 0, 7, 1, 0); mid();
      check("F_sat1", stall_cycles, 32'hFFFF_FFFF);
      put(1, 7, 7, 1, 1, 6, 0, 0);
      put(1, 0, 0, 0, 0, 9, 1, 0);
      put(1, 9, 9, 1, 1, 6, 0, 0);
      idle(1); mid();
      check("F_sat3", stall_cycles, 32'hFFFF_FFFF);

      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         put(($urandom_range(0, 99) < 80) ? 1 : 0,
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             ($urandom_range(0, 99) < 70) ? 1 : 0, ($urandom_range(0, 99) < 70) ? 1 : 0,
             int'($urandom_range(0, 7)),
             ($urandom_range(0, 99) < 30) ? 1 : 0, ($urandom_range(0, 99) < 10) ? 1 : 0);
         reset = ($urandom_range(0, 199) == 0);
      end
      reset = 1'b0;
      idle(3);
      mid();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
